or_n_sticky: RTL

Parametrised N-input OR combiner with input synchronisation, a per-channel edge/level mode and sticky capture. It merges asynchronous status and request lines (keyboard strobe, video busy, cursor blink tick, PIA flags) into one registered "any" output. It also latches which channels fired until software or the controller clears them. It sits between raw board/peripheral signals and the terminal control logic.

---
 rtl/or_n_sticky_sync_chain.sv | 32 +++
 rtl/or_n_sticky.sv | 82 ++++++++
 2 files changed

// File: rtl/or_n_sticky_sync_chain.sv
// sync_chain: single-bit flop synchroniser of configurable depth.
// DEPTH = 0 passes the input straight through for already-synchronous sources.
module sync_chain #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (DEPTH == 0) begin : g_bypass
    assign q = d;
  end else begin : g_chain
    logic [DEPTH-1:0] stage_r;

    // Shift the raw input through DEPTH flops; stage 0 is the metastability catcher.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stage_r <= '0;
      end else begin
        stage_r[0] <= d;
        for (int k = 1; k < DEPTH; k++) begin
          stage_r[k] <= stage_r[k-1];
        end
      end
    end

    assign q = stage_r[DEPTH-1];
  end

endmodule

// File: rtl/or_n_sticky.sv
// or_n_sticky: synchronised N-input OR combiner with per-channel edge/level capture,
// sticky pending flags, first-captured index and overflow detection.
module or_n_sticky #(
  parameter int             N           = 3,
  parameter int             SYNC_STAGES = 2,
  parameter logic [N-1:0]   EDGE_MASK   = '0,
  parameter int             IDX_W       = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     in_req,
  input  logic [N-1:0]     en_mask,
  input  logic             clr,
  input  logic [N-1:0]     clr_sel,
  output logic             y_level,
  output logic             y_sticky,
  output logic [N-1:0]     pending,
  output logic [IDX_W-1:0] first_idx,
  output logic             overflow
);

  logic [N-1:0]     sync_s;
  logic [N-1:0]     hist_r;
  logic [N-1:0]     ev_s;
  logic [N-1:0]     clr_hit_s;
  logic [N-1:0]     ovf_hit_s;
  logic             clr_all_s;
  logic [IDX_W-1:0] pick_s;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [N-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = IDX_W'(i);
      end
    end
    return idx;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_sync
    sync_chain #(.DEPTH(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (in_req[g]),
      .q     (sync_s[g])
    );
  end

  // Event qualification; level channels are kept out of overflow since a held level re-fires.
  always_comb begin
    clr_hit_s = clr ? clr_sel : '0;
    clr_all_s = clr & (&clr_sel);
    ev_s      = en_mask & ((EDGE_MASK & sync_s & ~hist_r) | (~EDGE_MASK & sync_s));
    ovf_hit_s = ev_s & pending & ~clr_hit_s & EDGE_MASK;
    pick_s    = lowest_set(ev_s);
  end

  // Capture state: edge history, level output, sticky flags, first index, overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_r    <= '0;
      y_level   <= 1'b0;
      pending   <= '0;
      first_idx <= '0;
      overflow  <= 1'b0;
    end else begin
      hist_r   <= sync_s;
      y_level  <= |(sync_s & en_mask);
      pending  <= ev_s | (pending & ~clr_hit_s);
      overflow <= (|ovf_hit_s) | (overflow & ~clr_all_s);
      if ((pending == '0) && (ev_s != '0)) begin
        first_idx <= pick_s;
      end else begin
        first_idx <= first_idx;
      end
    end
  end

  assign y_sticky = |pending;

endmodule
